// File: rtl/pattern_gen_stream.sv
// Test-pattern generator: one NUM_LINES x LINE_LEN frame per start on a valid/ready stream.
// Optional PRBS mode (mode 5) is built only when PATGEN_PRBS_EN is defined.
module pattern_gen_stream #(
    parameter int PIX_W     = 12,
    parameter int LINE_LEN  = 1290,
    parameter int NUM_LINES = 24,
    parameter int HBLANK    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [PIX_W-1:0] const_val,
    input  logic [2:0]       cb_log2,
    input  logic             cb_inv,
    input  logic [PIX_W-1:0] ramp_dx,
    input  logic [PIX_W-1:0] ramp_dy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam int XW  = $clog2(LINE_LEN);
    localparam int YW  = $clog2(NUM_LINES);
    localparam int HBW = $clog2(HBLANK + 2);
    localparam logic [XW-1:0]  X_LAST  = XW'(LINE_LEN - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(NUM_LINES - 1);
    localparam logic [HBW-1:0] HB_LAST = HBW'((HBLANK > 0) ? HBLANK - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK} state_t;
    typedef enum logic [2:0] {
        M_NONE = 3'd0, M_GRAY = 3'd1, M_CONST = 3'd2, M_CHECKER = 3'd3, M_RAMP = 3'd4, M_PRBS = 3'd5
    } mode_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [HBW-1:0]   hb_q, hb_d;
    logic [PIX_W-1:0] base_q, base_d, ramp_q, ramp_d;
    logic             done_q, done_d, err_q, err_d;
    mode_t            mode_q;
    logic [PIX_W-1:0] cval_q, dx_q, dy_q;
    logic [2:0]       cbl_q;
    logic             cbi_q;
    logic             mode_ok, load, xfer, x_last, y_last, cb_bit;
    logic [PIX_W-1:0] pix;

    always_comb begin
`ifdef PATGEN_PRBS_EN
        mode_ok = mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
`else
        mode_ok = mode inside {3'd1, 3'd2, 3'd3, 3'd4};
`endif
        x_last  = (x_q == X_LAST);
        y_last  = (y_q == Y_LAST);
        xfer    = (state_q == S_ACTIVE) && m_ready && !abort;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hb_d    = hb_q;
        base_d  = base_q;
        ramp_d  = ramp_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && mode_ok) begin
                        state_d = S_ACTIVE;
                        load    = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        base_d  = '0;
                        ramp_d  = '0;
                    end else if (start) begin
                        err_d = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (m_ready) begin
                        if (x_last) begin
                            x_d = '0;
                            if (y_last) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                // Ramp line base moves by dy; pixel accumulator restarts from the new base.
                                y_d    = y_q + 1'b1;
                                base_d = base_q + dy_q;
                                ramp_d = base_q + dy_q;
                                if (HBLANK > 0) begin
                                    state_d = S_HBLANK;
                                    hb_d    = HB_LAST;
                                end
                            end
                        end else begin
                            x_d    = x_q + 1'b1;
                            ramp_d = ramp_q + dx_q;
                        end
                    end
                end
                S_HBLANK: begin
                    if (hb_q == '0) state_d = S_ACTIVE;
                    else            hb_d    = hb_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hb_q    <= '0;
            base_q  <= '0;
            ramp_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= M_NONE;
            cval_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            cbl_q   <= '0;
            cbi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hb_q    <= hb_d;
            base_q  <= base_d;
            ramp_q  <= ramp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                mode_q <= mode_t'(mode);
                cval_q <= const_val;
                dx_q   <= ramp_dx;
                dy_q   <= ramp_dy;
                cbl_q  <= cb_log2;
                cbi_q  <= cb_inv;
            end
        end
    end

`ifdef PATGEN_PRBS_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfsr_q <= 16'hACE1;
        else if (load) lfsr_q <= 16'hACE1;
        else if (xfer) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`endif

    always_comb begin
        cb_bit = 1'(x_q >> cbl_q) ^ 1'(y_q >> cbl_q) ^ cbi_q;
        pix    = '0;
        case (mode_q)
            M_GRAY:    pix = PIX_W'(x_q ^ (x_q >> 1));
            M_CONST:   pix = cval_q;
            M_CHECKER: pix = {PIX_W{cb_bit}};
            M_RAMP:    pix = ramp_q;
`ifdef PATGEN_PRBS_EN
            M_PRBS:    pix = lfsr_q[PIX_W-1:0];
`endif
            default:   pix = '0;
        endcase
    end

    assign m_valid = (state_q == S_ACTIVE);
    assign m_data  = m_valid ? pix : '0;
    assign m_sof   = m_valid && (x_q == '0) && (y_q == '0);
    assign m_eol   = m_valid && x_last;
    assign m_eof   = m_valid && x_last && y_last;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

// File: doc/pattern_gen_stream.md
Name: pattern_gen_stream

Overview:
- Parametrised next-generation test-pattern generator producing one frame of NUM_LINES x LINE_LEN pixels per start command.
- Output is a valid/ready pixel stream with sof/eol/eof markers, so downstream back-pressure is honoured.
- Configuration is latched at frame start. Supports Gray-code, constant, programmable-size checkerboard, 2-D ramp and optional PRBS patterns.
- Sits between the control register block and the display/serialiser datapath.

Parameters:
- PIX_W, 12, pixel width in bits (4..16).
- LINE_LEN, 1290, pixels per line (>=2).
- NUM_LINES, 24, lines per frame (>=2).
- HBLANK, 0, idle cycles inserted after each line's eol beat (0 = back-to-back lines).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  synchronous frame abort
- mode  in  3  1=GRAY 2=CONST 3=CHECKER 4=RAMP 5=PRBS; others invalid
- const_val  in  PIX_W  CONST pixel value
- cb_log2  in  3  checker square size = 2^cb_log2 pixels/lines
- cb_inv  in  1  invert checker phase
- ramp_dx  in  PIX_W  per-pixel ramp increment
- ramp_dy  in  PIX_W  per-line ramp increment
- m_valid  out  1  pixel valid
- m_ready  in  1  downstream ready
- m_data  out  PIX_W  pixel value
- m_sof  out  1  first pixel of frame
- m_eol  out  1  last pixel of line
- m_eof  out  1  last pixel of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame completed
- cfg_err  out  1  one-cycle pulse, start rejected

Behaviour:
- Clock/reset: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; state IDLE; x=0, y=0; LFSR=16'hACE1.
- States: IDLE, ACTIVE, HBLANK_WAIT.
- Indices: x = pixel index 0..LINE_LEN-1, width $clog2(LINE_LEN). y = line index 0..NUM_LINES-1, width $clog2(NUM_LINES).
- A beat is transferred when m_valid & m_ready.
- IDLE, start=1 with valid mode: latch mode/const_val/cb_log2/cb_inv/ramp_dx/ramp_dy; busy=1.
  - Next cycle: ACTIVE with m_valid=1, pixel(0,0), m_sof=1.
  - Latency start->first valid = 1 cycle.
- IDLE, start=1 with invalid mode: cfg_err pulses 1 cycle; stay IDLE.
- Config input changes mid-frame have no effect.
- ACTIVE:
  - While m_valid & !m_ready: m_data and all markers are held stable.
  - On each transfer, advance x. When x=LINE_LEN-1, that beat carries m_eol=1.
  - After the eol transfer: x=0, y+1. If HBLANK>0, go to HBLANK_WAIT (m_valid=0 for exactly HBLANK cycles); else present the next line's pixel 0 in the next cycle.
  - Throughput with m_ready held high is 1 pixel/cycle within a line.
- Last beat (x=LINE_LEN-1, y=NUM_LINES-1): m_eol=1 and m_eof=1.
  - After its transfer: m_valid=0, done=1 for one cycle, busy=0, return to IDLE. No HBLANK after the final line.
- Pixel functions (all arithmetic modulo 2^PIX_W):
  - GRAY: x ^ (x>>1), zero-extended or truncated to PIX_W.
  - CONST: const_val.
  - CHECKER: (((x>>cb_log2) ^ (y>>cb_log2)) & 1) ^ cb_inv; 1 outputs all-ones, 0 outputs all-zeros.
  - RAMP: y*ramp_dy + x*ramp_dx, computed incrementally with no multiplier. The line base adds ramp_dy per line; the pixel adds ramp_dx per transfer.
  - PRBS: LFSR x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback into bit 0. Seeded 16'hACE1 at frame start; advances once per transfer; m_data = lfsr[PIX_W-1:0].
- abort=1 in any state: next cycle state=IDLE, m_valid=0, busy=0; done and cfg_err stay 0. Abort wins over a simultaneous start or transfer, and the aborted beat does not count as transferred.
- start while busy is ignored.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
- Macro PATGEN_PRBS_EN.
- Defined: mode 5 = PRBS as above; the 16-bit LFSR is instantiated.
- Undefined: no LFSR logic; mode 5 is invalid, so start with mode 5 pulses cfg_err and the block stays IDLE.

Test Plan:
- Params LINE_LEN=8, NUM_LINES=4, HBLANK=0, m_ready=1, mode=GRAY, start pulse: valid 1 cycle after start; line data 0,1,3,2,6,7,5,4 repeated 4 times; sof on beat 0; eol on beats 7/15/23/31; eof on beat 31; done 1 cycle after beat 31.
- CONST const_val=12'hA5A with m_ready toggling 1,0,0,1,...: every held beat keeps m_data=12'hA5A and stable markers; exactly 32 transfers; eof on the 32nd.
- CHECKER cb_log2=1, cb_inv=0, PIX_W=12: line0 = 000,000,FFF,FFF,000,000,FFF,FFF; line2 = FFF,FFF,000,000,...; with cb_inv=1 all of these are inverted.
- RAMP ramp_dx=4, ramp_dy=12'h50A, HBLANK=2: line1 starts at 12'h50A and increments by 4; exactly 2 invalid cycles after each of eol beats 0..2; none after the last.
- Abort on beat 10, simultaneous with start: m_valid=0 next cycle, busy=0, no done. A new start 2 cycles later restarts at pixel(0,0) with sof=1.
- mode=0 start -> cfg_err 1-cycle pulse, m_valid stays 0. mode=5 start: with PATGEN_PRBS_EN, first data = 12'hCE1, second = 12'h9C3; without it, cfg_err pulse.
